rnn_x_feeder: RTL



---
 rtl/rnn_pkg.sv | 15 +
 rtl/rnn_word_fifo.sv | 59 +++++
 rtl/rnn_x_feeder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/rnn_pkg.sv
// Shared types and widths for the RNN datapath blocks.
// Holds the x-feeder state encoding and the vector widths used downstream.
package rnn_pkg;

  localparam int XW = 32;
  localparam int HW = 20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_ARMED,
    ST_RUN
  } feed_state_t;

endpackage

// File: rtl/rnn_word_fifo.sv
// Show-ahead word FIFO: head is valid combinationally; push/pop/flush take effect next cycle.
// Pushes while full and pops while empty are dropped; no backpressure is exported.
module rnn_word_fifo
  import rnn_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [XW-1:0] push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [XW-1:0] head,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [XW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_push    = push && (count != FULL_CNT);
  assign do_pop     = pop && (count != '0);
  assign wr_ptr_nxt = do_push ? wr_ptr + 1'b1 : wr_ptr;
  assign head       = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      // Flush wins over any pop in the same cycle: everything still queued is discarded.
      if (flush) begin
        rd_ptr <= wr_ptr_nxt;
        count  <= '0;
      end else begin
        if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/rnn_x_feeder.sv
// Packs a byte frame little-endian into 32-bit words, buffers it, then serves one word per i_en.
// Word visible 1 cycle after its last byte; s_ready drops only while ARMED/RUN, never on overflow.
module rnn_x_feeder
  import rnn_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [7:0]    s_data,
  input  logic          s_last,
  input  logic          busy,
  input  logic          i_en,
  output logic          ready,
  output logic [XW-1:0] idata,
  output logic [AW:0]   words,
  output logic          err_ovf,
  output logic          err_udf
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  feed_state_t   state;
  feed_state_t   state_nxt;
  logic [1:0]    lane;
  logic [1:0]    lane_eff;
  logic [23:0]   wbuf;
  logic          accept;
  logic          commit;
  logic          pop;
  logic          flush;
  logic [XW-1:0] pack_word;

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    ready     = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    case (state)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) state_nxt = s_last ? ST_ARMED : ST_FILL;
      end
      ST_FILL: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        ready = 1'b1;
        if (busy) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        pop = i_en;
        if (!busy) begin
          flush     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept   = s_valid && s_ready;
  // The first byte of a frame always starts a fresh word regardless of leftover lane state.
  assign lane_eff = (state == ST_IDLE) ? 2'd0 : lane;
  assign commit   = accept && ((lane_eff == 2'd3) || s_last);

  always_comb begin
    pack_word = '0;
    for (int k = 0; k < 3; k++) begin
      if (k < int'(lane_eff)) pack_word[8*k +: 8] = wbuf[8*k +: 8];
    end
    pack_word[{lane_eff, 3'b000} +: 8] = s_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      lane    <= 2'd0;
      wbuf    <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (commit) begin
          lane <= 2'd0;
        end else begin
          lane <= lane_eff + 1'b1;
          case (lane_eff)
            2'd0:    wbuf[7:0]   <= s_data;
            2'd1:    wbuf[15:8]  <= s_data;
            default: wbuf[23:16] <= s_data;
          endcase
        end
      end
      if (state == ST_IDLE && accept) begin
        err_ovf <= 1'b0;
        err_udf <= 1'b0;
      end
      if (commit && words == FULL_CNT) err_ovf <= 1'b1;
      if (pop && words == '0) err_udf <= 1'b1;
    end
  end

  rnn_word_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (commit),
    .push_data(pack_word),
    .pop      (pop),
    .flush    (flush),
    .head     (idata),
    .count    (words)
  );

endmodule
